// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller with a shared bidirectional data bus.
// Define SRAM_CTRL_TURNAROUND_EN to add a dead TURN cycle after every access.
`timescale 1ns/1ps

module sram_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ack,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  inout  wire  [DATA_W-1:0] sram
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

`ifdef SRAM_CTRL_TURNAROUND_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_TURN  = 2'd3
  } state_t;
  localparam state_t EXIT_ST = ST_TURN;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;
  localparam state_t EXIT_ST = ST_IDLE;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  wdata_q;
  logic               drive_q;
  logic               accept_wr, accept_rd, capture;
  logic               busy_d, ce_n_d, we_n_d, oe_n_d, drive_d;

  // Next-state, wait counter and next-cycle strobe decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          state_d   = ST_WRITE;
          cnt_d     = CNT_W'(WAIT_CYCLES - 1);
          accept_wr = 1'b1;
        end else if (rd_req) begin
          state_d   = ST_READ;
          cnt_d     = CNT_W'(WAIT_CYCLES - 1);
          accept_rd = 1'b1;
        end
      end
      ST_WRITE: begin
        if (cnt_q == '0) state_d = EXIT_ST;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          state_d = EXIT_ST;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    ce_n_d  = !((state_d == ST_WRITE) || (state_d == ST_READ));
    we_n_d  = (state_d != ST_WRITE);
    oe_n_d  = (state_d != ST_READ);
    drive_d = (state_d == ST_WRITE);
  end

  // State and registered outputs; reset also releases the bus immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wdata_q   <= '0;
      drive_q   <= 1'b0;
      addr      <= '0;
      rd_data   <= '0;
      ack       <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drive_q   <= drive_d;
      ack       <= accept_wr | accept_rd;
      rd_valid  <= capture;
      busy      <= busy_d;
      sram_ce_n <= ce_n_d;
      sram_we_n <= we_n_d;
      sram_oe_n <= oe_n_d;
      if (accept_wr | accept_rd) addr    <= addr_in;
      if (accept_wr)             wdata_q <= wr_data;
      if (capture)               rd_data <= sram;
    end
  end

  assign sram = drive_q ? wdata_q : {DATA_W{1'bz}};

  // Bus may only be driven while the write strobe is active
  a_drive_only_in_write: assert property (@(posedge clk) disable iff (rst)
    drive_q |-> (state_q == ST_WRITE) && sram_oe_n && !sram_we_n);
  a_ack_pulse: assert property (@(posedge clk) disable iff (rst) ack |=> !ack);
  a_rd_valid_pulse: assert property (@(posedge clk) disable iff (rst) rd_valid |=> !rd_valid);

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural asynchronous SRAM model.
`timescale 1ns/1ps

module tb_sram_ctrl;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned WAIT_CYCLES = 2;
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam int unsigned TURN_CYC = 1;
`else
  localparam int unsigned TURN_CYC = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_req, rd_req;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wr_data;
  logic              ack, busy, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] addr;
  logic              sram_ce_n, sram_we_n, sram_oe_n;
  wire  [DATA_W-1:0] sram;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] zval;
  logic [DATA_W-1:0] sb [$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, n_ack = 0;
  int last_ack_cyc = 0, prev_ack_cyc = 0, rv_cyc = 0;
  int we_run = 0, last_we_run = 0, busy_run = 0, last_busy_run = 0;
  logic ack_prev = 1'b0, rv_prev = 1'b0;

  sram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .addr_in(addr_in),
    .wr_data(wr_data), .ack(ack), .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid),
    .addr(addr), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram(sram)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: drives the bus only while output-enabled, latches writes
  assign sram = (!sram_ce_n && !sram_oe_n) ? mem[addr] : {DATA_W{1'bz}};
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[addr] <= sram;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Protocol monitor and scoreboard consumer
  always @(negedge clk) begin
    if (!rst) begin
      if (ack) begin
        check("ack_one_cycle", 32'(ack_prev), 32'd0);
        n_ack++;
        prev_ack_cyc = last_ack_cyc;
        last_ack_cyc = cyc;
      end
      if (rd_valid) begin
        check("rd_valid_one_cycle", 32'(rv_prev), 32'd0);
        rv_cyc = cyc;
        if (sb.size() == 0) check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
        else                check("rd_data", 32'(rd_data), 32'(sb.pop_front()));
      end
      if (!sram_oe_n) begin
        check("bus_read_no_contention", 32'(sram), 32'(mem[addr]));
        check("oe_we_exclusive", 32'(sram_we_n), 32'd1);
      end
      if (sram_ce_n) check("bus_idle_hiz", 32'(sram), 32'(zval));
      if (!sram_we_n) we_run++;
      else if (we_run != 0) begin last_we_run = we_run; we_run = 0; end
      if (busy) busy_run++;
      else if (busy_run != 0) begin last_busy_run = busy_run; busy_run = 0; end
    end
    ack_prev = ack;
    rv_prev  = rd_valid;
  end

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!ack && n < 20) begin @(negedge clk); n++; end
    check(tag, 32'(ack), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    check(tag, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_req = 1'b1; addr_in = a; wr_data = d;
    wait_ack("wr_ack");
    wr_req = 1'b0;
    wait_idle("wr_idle");
    check("we_low_cycles", 32'(last_we_run), 32'(WAIT_CYCLES));
    check("wr_busy_cycles", 32'(last_busy_run), 32'(WAIT_CYCLES + TURN_CYC));
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    sb.push_back(e);
    rd_req = 1'b1; addr_in = a;
    wait_ack("rd_ack");
    rd_req = 1'b0;
    wait_idle("rd_idle");
    check("rd_valid_latency", 32'(rv_cyc - last_ack_cyc), 32'(WAIT_CYCLES));
    check("rd_sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks_before;
    zval = {DATA_W{1'bz}};
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[1] = 8'h81;
    mem[6] = 8'h77;
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; addr_in = '0; wr_data = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'b111);
    check("rst_bus_hiz", 32'(sram), 32'(zval));
    rst = 1'b0;
    @(negedge clk);

    // Abort a read with reset during its second cycle
    rd_req = 1'b1; addr_in = 3'd6;
    wait_ack("abort_ack");
    rd_req = 1'b0;
    check("abort_oe_active", 32'(sram_oe_n), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'b111);
    check("abort_bus_hiz", 32'(sram), 32'(zval));
    check("abort_no_rd_valid", 32'(rd_valid), 32'd0);
    check("abort_rd_data", 32'(rd_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_rd_data_held", 32'(rd_data), 32'd0);

    // Write then read back through the SRAM model
    do_write(3'd3, 8'hA5);
    check("mem3_written", 32'(mem[3]), 32'hA5);
    do_read(3'd3, 8'hA5);

    // Simultaneous requests: write wins, read stays pending
    sb.push_back(8'h81);
    wr_req = 1'b1; rd_req = 1'b1; addr_in = 3'd5; wr_data = 8'h3C;
    wait_ack("simul_wr_ack");
    check("simul_write_first", 32'({sram_we_n, sram_oe_n}), 32'b01);
    check("simul_wr_addr", 32'(addr), 32'd5);
    wr_req = 1'b0; addr_in = 3'd1;
    @(negedge clk);
    wait_ack("simul_rd_ack");
    rd_req = 1'b0;
    check("simul_read_second", 32'({sram_we_n, sram_oe_n}), 32'b10);
    check("simul_rd_addr", 32'(addr), 32'd1);
    wait_idle("simul_idle");
    check("simul_issue_interval", 32'(last_ack_cyc - prev_ack_cyc), 32'(WAIT_CYCLES + 1 + TURN_CYC));
    check("simul_sb_drained", 32'(sb.size()), 32'd0);
    check("mem5_written", 32'(mem[5]), 32'h3C);
    check("simul_rd_data_held", 32'(rd_data), 32'h81);

    // Short read pulse during a write is ignored
    acks_before = n_ack;
    wr_req = 1'b1; addr_in = 3'd4; wr_data = 8'h11;
    wait_ack("ign_wr_ack");
    wr_req = 1'b0; rd_req = 1'b1; addr_in = 3'd1;
    @(negedge clk);
    rd_req = 1'b0;
    wait_idle("ign_idle");
    repeat (5) @(negedge clk);
    check("ign_ack_count", 32'(n_ack), 32'(acks_before + 1));
    check("ign_busy", 32'(busy), 32'd0);
    check("ign_rd_data_held", 32'(rd_data), 32'h81);
    check("mem4_written", 32'(mem[4]), 32'h11);

    // Back-to-back write then read across the bus direction change
    sb.push_back(8'h5A);
    wr_req = 1'b1; addr_in = 3'd2; wr_data = 8'h5A;
    wait_ack("b2b_wr_ack");
    wr_req = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    wait_ack("b2b_rd_ack");
    rd_req = 1'b0;
    wait_idle("b2b_idle");
    check("b2b_issue_interval", 32'(last_ack_cyc - prev_ack_cyc), 32'(WAIT_CYCLES + 1 + TURN_CYC));
    check("b2b_sb_drained", 32'(sb.size()), 32'd0);
    check("b2b_rd_data", 32'(rd_data), 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
